// File: rtl/alu_control_sequencer.sv
// Multi-cycle control sequencer. It fetches an instruction, decodes it, drives the ALU
// controls, resolves branches and jumps from the ALU results, and runs the memory and
// register-file write handshakes.
module alu_control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic        aluAltOp,
  output logic [3:0]  aluFunc,
  output logic        aluSrcImm,
  output logic [31:0] immOut,
  input  logic [31:0] aluResult,
  input  logic        beqIn,
  output logic [3:0]  rdAddr,
  output logic [3:0]  rs1Addr,
  output logic [3:0]  rs2Addr,
  output logic        regWe,
  output logic [1:0]  regWrSel,
  output logic [31:0] pcPlus4,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  input  logic        dmemReady,
  output logic        illegalOp
);

  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  localparam logic [3:0] OP_ALUR = 4'b1100, OP_ALUI = 4'b0100, OP_CMPR = 4'b1101,
                         OP_CMPI = 4'b0101, OP_BR   = 4'b0110, OP_LW   = 4'b0111,
                         OP_SW   = 4'b0011, OP_JAL  = 4'b1011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, aluq_q, aluq_d;
  logic        taken_q, taken_d;

  logic [3:0]  op;
  logic [31:0] imm_sext, pc_inc, br_target;
  logic        is_lw, is_sw, is_jal, is_br, legal;
  logic        dec_alt, dec_src, dec_we;
  logic [3:0]  dec_func;
  logic [1:0]  dec_sel;

  assign op       = ir_q[31:28];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_inc   = pc_q + 32'd4;
  assign br_target = pc_inc + (imm_sext << 2);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_jal   = (op == OP_JAL);
  assign is_br    = (op == OP_BR);

  // Instruction decode: ALU controls and write-back behaviour per opcode
  always_comb begin
    legal    = 1'b1;
    dec_alt  = 1'b0;
    dec_func = 4'b0000;
    dec_src  = 1'b0;
    dec_we   = 1'b0;
    dec_sel  = 2'd0;
    unique case (op)
      OP_ALUR: begin dec_func = ir_q[27:24]; dec_we = 1'b1; end
      OP_ALUI: begin dec_func = ir_q[27:24]; dec_src = 1'b1; dec_we = 1'b1; end
      OP_CMPR: begin dec_alt = 1'b1; dec_func = ir_q[27:24]; dec_we = 1'b1; end
      OP_CMPI: begin dec_alt = 1'b1; dec_func = ir_q[27:24]; dec_src = 1'b1; dec_we = 1'b1; end
      OP_BR:   begin dec_alt = 1'b1; dec_func = ir_q[27:24]; end
      OP_LW:   begin dec_src = 1'b1; dec_we = 1'b1; dec_sel = 2'd1; end
      OP_SW:   dec_src = 1'b1;
      OP_JAL:  begin dec_src = 1'b1; dec_we = 1'b1; dec_sel = 2'd2; end
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (imemValid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:    if (dmemReady) state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  // Datapath registers: PC, IR, captured ALU result and branch flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      aluq_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      aluq_q  <= aluq_d;
      taken_q <= taken_d;
    end
  end

  // Datapath next values; PC only moves when leaving MEM (store) or WB
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    aluq_d  = aluq_q;
    taken_d = taken_q;
    if (state_q == S_FETCH && imemValid) ir_d = imemData;
    if (state_q == S_EXEC) begin
      aluq_d  = aluResult;
      taken_d = beqIn;
    end
    if (state_q == S_MEM && dmemReady && is_sw) pc_d = pc_inc;
    if (state_q == S_WB) begin
      if (is_br && taken_q) pc_d = br_target;
      else if (is_jal)      pc_d = aluq_q;
      else                  pc_d = pc_inc;
    end
  end

  // Outputs: controls only live in EXEC/MEM/WB, fields always track IR
  always_comb begin
    imemReq   = (state_q == S_FETCH);
    aluAltOp  = 1'b0;
    aluFunc   = 4'b0000;
    aluSrcImm = 1'b0;
    regWe     = 1'b0;
    regWrSel  = 2'd0;
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    dmemAddr  = '0;
    illegalOp = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      aluAltOp  = dec_alt;
      aluFunc   = dec_func;
      aluSrcImm = dec_src;
    end
    if (state_q == S_MEM) begin
      dmemReq  = 1'b1;
      dmemWe   = is_sw;
      dmemAddr = aluq_q;
    end
    if (state_q == S_WB) begin
      regWe     = legal && dec_we;
      regWrSel  = (legal && dec_we) ? dec_sel : 2'd0;
      illegalOp = !legal;
    end
  end

  assign imemAddr = pc_q;
  assign pcPlus4  = pc_inc;
  assign immOut   = is_jal ? (imm_sext << 2) : imm_sext;
  assign rdAddr   = ir_q[23:20];
  assign rs1Addr  = ir_q[19:16];
  assign rs2Addr  = ir_q[15:12];

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench: a table of instructions is run back to back, with the bench acting
// as the instruction memory, the data memory and the ALU, followed by reset sequences.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imemReq, imemValid;
  logic [31:0] imemAddr, imemData;
  logic        aluAltOp, aluSrcImm;
  logic [3:0]  aluFunc;
  logic [31:0] immOut, aluResult;
  logic        beqIn;
  logic [3:0]  rdAddr, rs1Addr, rs2Addr;
  logic        regWe;
  logic [1:0]  regWrSel;
  logic [31:0] pcPlus4;
  logic        dmemReq, dmemWe, dmemReady;
  logic [31:0] dmemAddr;
  logic        illegalOp;

  int n_pass = 0;
  int n_tot  = 0;

  alu_control_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid), .imemData(imemData),
    .aluAltOp(aluAltOp), .aluFunc(aluFunc), .aluSrcImm(aluSrcImm), .immOut(immOut),
    .aluResult(aluResult), .beqIn(beqIn),
    .rdAddr(rdAddr), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .regWe(regWe), .regWrSel(regWrSel), .pcPlus4(pcPlus4),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemReady(dmemReady),
    .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, alu;
    logic        beq;
    int          wt, cyc;
    logic        alt;
    logic [3:0]  func;
    logic        src;
    logic [31:0] imm;
    int          we_n;
    logic [1:0]  sel;
    logic [3:0]  rd;
    logic [31:0] link;
    int          req_n;
    logic        dwe;
    logic [31:0] daddr;
    int          ill_n;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Runs one instruction starting at the negedge of a FETCH cycle; returns at the next FETCH
  task automatic run(input int idx, input vec_t v);
    int cyc = 0, we_n = 0, req_n = 0, ill_n = 0;
    logic done = 1'b0;
    logic alt = 1'b0, src = 1'b0, dwe = 1'b0;
    logic [3:0] func = '0, rd = '0;
    logic [1:0] sel = '0;
    logic [31:0] imm = '0, link = '0, daddr = '0;
    chk($sformatf("v%0d fetch_req", idx), {31'd0, imemReq}, 32'd1);
    chk($sformatf("v%0d fetch_pc", idx), imemAddr, v.pc);
    imemData = v.instr; imemValid = 1'b1; aluResult = v.alu; beqIn = v.beq; dmemReady = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      imemData = 32'hDEAD_BEEF;   // valid stays high; must not be taken outside FETCH
      if (cyc == 2) begin alt = aluAltOp; func = aluFunc; src = aluSrcImm; imm = immOut; end
      if (regWe) begin we_n++; sel = regWrSel; rd = rdAddr; link = pcPlus4; end
      if (illegalOp) ill_n++;
      if (dmemReq) begin
        req_n++; daddr = dmemAddr; dwe = dmemWe;
        dmemReady = (req_n > v.wt);
      end else dmemReady = 1'b0;
      if (imemReq) done = 1'b1;
    end
    chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d aluAltOp", idx), {31'd0, alt}, {31'd0, v.alt});
    chk($sformatf("v%0d aluFunc", idx), {28'd0, func}, {28'd0, v.func});
    chk($sformatf("v%0d aluSrcImm", idx), {31'd0, src}, {31'd0, v.src});
    chk($sformatf("v%0d immOut", idx), imm, v.imm);
    chk($sformatf("v%0d regWe_cycles", idx), we_n, v.we_n);
    if (v.we_n > 0) begin
      chk($sformatf("v%0d regWrSel", idx), {30'd0, sel}, {30'd0, v.sel});
      chk($sformatf("v%0d rdAddr", idx), {28'd0, rd}, {28'd0, v.rd});
      if (v.sel == 2'd2) chk($sformatf("v%0d link", idx), link, v.link);
    end
    chk($sformatf("v%0d dmemReq_cycles", idx), req_n, v.req_n);
    if (v.req_n > 0) begin
      chk($sformatf("v%0d dmemAddr", idx), daddr, v.daddr);
      chk($sformatf("v%0d dmemWe", idx), {31'd0, dwe}, {31'd0, v.dwe});
    end
    chk($sformatf("v%0d illegal_pulses", idx), ill_n, v.ill_n);
    chk($sformatf("v%0d next_pc", idx), imemAddr, v.npc);
  endtask

  initial begin
    //          pc            instr         alu           beq wt cyc alt func  src imm           we sel rd    link          req dwe daddr        ill npc
    tbl[0]  = '{32'h0,        32'hC0312000, 32'h55,       0, 0, 4, 0, 4'h0, 0, 32'h2000,     1, 0, 4'h3, 32'h0,        0, 0, 32'h0,        0, 32'h4};
    tbl[1]  = '{32'h4,        32'h4251FFF0, 32'h66,       0, 0, 4, 0, 4'h2, 1, 32'hFFFFFFF0, 1, 0, 4'h5, 32'h0,        0, 0, 32'h0,        0, 32'h8};
    tbl[2]  = '{32'h8,        32'h53620007, 32'h1,        0, 0, 4, 1, 4'h3, 1, 32'h7,        1, 0, 4'h6, 32'h0,        0, 0, 32'h0,        0, 32'hC};
    tbl[3]  = '{32'hC,        32'hD4712000, 32'h0,        0, 0, 4, 1, 4'h4, 0, 32'h2000,     1, 0, 4'h7, 32'h0,        0, 0, 32'h0,        0, 32'h10};
    tbl[4]  = '{32'h10,       32'h61010003, 32'h1,        1, 0, 4, 1, 4'h1, 0, 32'h3,        0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 32'h20};
    tbl[5]  = '{32'h20,       32'h61010003, 32'h0,        0, 0, 4, 1, 4'h1, 0, 32'h3,        0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 32'h24};
    tbl[6]  = '{32'h24,       32'h7781FFFC, 32'h1000,     0, 3, 8, 0, 4'h0, 1, 32'hFFFFFFFC, 1, 1, 4'h8, 32'h0,        4, 0, 32'h1000,     0, 32'h28};
    tbl[7]  = '{32'h28,       32'h30010010, 32'h2000,     0, 1, 5, 0, 4'h0, 1, 32'h10,       0, 0, 4'h0, 32'h0,        2, 1, 32'h2000,     0, 32'h2C};
    tbl[8]  = '{32'h2C,       32'hB5E10002, 32'h108,      0, 0, 4, 0, 4'h0, 1, 32'h8,        1, 2, 4'hE, 32'h30,       0, 0, 32'h0,        0, 32'h108};
    tbl[9]  = '{32'h108,      32'hF1234567, 32'h0,        0, 0, 4, 0, 4'h0, 0, 32'h4567,     0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 32'h10C};
    tbl[10] = '{32'h10C,      32'h00000000, 32'h0,        0, 0, 4, 0, 4'h0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 32'h110};
    tbl[11] = '{32'h110,      32'hB0E10002, 32'hFFFFFFFC, 0, 0, 4, 0, 4'h0, 1, 32'h8,        1, 2, 4'hE, 32'h114,      0, 0, 32'h0,        0, 32'hFFFFFFFC};
    tbl[12] = '{32'hFFFFFFFC, 32'hC0312000, 32'h0,        0, 0, 4, 0, 4'h0, 0, 32'h2000,     1, 0, 4'h3, 32'h0,        0, 0, 32'h0,        0, 32'h0};
    tbl[13] = '{32'h0,        32'h70810000, 32'h44,       0, 0, 5, 0, 4'h0, 1, 32'h0,        1, 1, 4'h8, 32'h0,        1, 0, 32'h44,       0, 32'h4};

    reset_n = 1'b0; imemValid = 1'b0; imemData = '0; aluResult = '0; beqIn = 1'b0; dmemReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst imemReq", {31'd0, imemReq}, 32'd0);
    chk("rst imemAddr", imemAddr, 32'h0);
    chk("rst pcPlus4", pcPlus4, 32'h4);
    chk("rst regWe", {31'd0, regWe}, 32'd0);
    chk("rst dmemReq", {31'd0, dmemReq}, 32'd0);
    chk("rst immOut", immOut, 32'h0);
    chk("rst aluctl", {26'd0, aluAltOp, aluFunc, aluSrcImm}, 32'd0);
    chk("rst illegalOp", {31'd0, illegalOp}, 32'd0);

    reset_n = 1'b1;
    #1 chk("init no fetch", {31'd0, imemReq}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 14; i++) run(i, tbl[i]);

    // Reset in the middle of a load that is still waiting on memory
    imemData = 32'h70810000; imemValid = 1'b1; aluResult = 32'h300; dmemReady = 1'b0;
    repeat (3) @(negedge clk);
    imemValid = 1'b0;
    chk("midrst in MEM", {31'd0, dmemReq}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst dmemReq", {31'd0, dmemReq}, 32'd0);
    chk("midrst pc", imemAddr, 32'h0);
    chk("midrst imemReq", {31'd0, imemReq}, 32'd0);
    chk("midrst regWe", {31'd0, regWe}, 32'd0);
    dmemReady = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst fetch", {31'd0, imemReq}, 32'd1);
    chk("late ready ignored", {30'd0, dmemReq, regWe}, 32'd0);
    @(negedge clk);
    chk("still fetching", {29'd0, imemReq, dmemReq, regWe}, 32'd4);
    chk("post rst pc", imemAddr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Multi-cycle control sequencer that fetches 32-bit instructions, decodes them, and drives the ALU's `aluAltOp`/`func` controls. It consumes the ALU's `dataOut` and `beqOut` back to resolve branches, jumps and memory addresses. It owns the PC and instruction register, and performs the instruction-memory, data-memory and register-file write handshakes. It sits between the memories/register file and the ALU in the processor datapath.

## Interface
- `RESET_PC`, default `32'h0000_0000`, PC loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imemReq` out 1: instruction fetch request.
- `imemAddr` out 32: current PC.
- `imemValid` in 1: fetch data valid.
- `imemData` in 32: instruction word.
- `aluAltOp` out 1: ALU mode, 0=arith/logic, 1=compare/branch.
- `aluFunc` out 4: ALU function code.
- `aluSrcImm` out 1: ALU data2 selects `immOut` (1) or rs2 (0).
- `immOut` out 32: sign-extended immediate (shifted left 2 for JAL).
- `aluResult` in 32: ALU `dataOut`.
- `beqIn` in 1: ALU `beqOut`.
- `rdAddr`, `rs1Addr`, `rs2Addr` out 4 each: register file indices.
- `regWe` out 1: register write strobe.
- `regWrSel` out 2: write-data select; 0=ALU result, 1=memory read data, 2=`pcPlus4`.
- `pcPlus4` out 32: PC+4 (link value).
- `dmemReq` out 1, `dmemWe` out 1, `dmemAddr` out 32: data-memory request.
- `dmemReady` in 1: data-memory access complete.
- `illegalOp` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Instruction fields:
  - `op`=[31:28], `fn`=[27:24], `rd`=[23:20], `rs1`=[19:16], `rs2`=[15:12], `imm`=[15:0].
  - `immOut` = sign-extended `imm`.
- Opcodes:
  - 1100 ALUR: `aluAltOp`=0, `aluFunc`=`fn`, reg source.
  - 0100 ALUI: `aluAltOp`=0, `aluFunc`=`fn`, imm source.
  - 1101 CMPR: `aluAltOp`=1, `aluFunc`=`fn`, reg source.
  - 0101 CMPI: `aluAltOp`=1, `aluFunc`=`fn`, imm source.
  - 0110 BR: `aluAltOp`=1, `aluFunc`=`fn`, reg source, no write.
  - 0111 LW and 0011 SW: `aluAltOp`=0, `aluFunc`=0000, imm source; address = rs1+sext(imm).
  - 1011 JAL: `aluAltOp`=0, `aluFunc`=0000, imm source, `immOut`=sext(imm)<<2; rd←PC+4; PC←`aluResult`.
  - Any other op: illegal.
- States: INIT, FETCH, DECODE, EXEC, MEM, WB.
  - INIT: one cycle after reset release → FETCH.
  - FETCH: `imemReq`=1. On `imemValid`=1, IR←`imemData` → DECODE. Otherwise hold.
  - DECODE: field outputs valid, so register reads settle → EXEC.
  - EXEC: ALU controls asserted. At the clock edge, capture `aluResult`→ALUQ and `beqIn`→TAKEN. LW/SW → MEM; all other ops → WB.
  - MEM: `dmemReq`=1, `dmemAddr`=ALUQ, `dmemWe`=1 for SW. Hold until `dmemReady`=1. Then LW → WB; SW → PC←PC+4 → FETCH.
  - WB: `regWe`=1 for ALUR/ALUI/CMPR/CMPI (sel 0), LW (sel 1), JAL (sel 2); otherwise 0. Next PC is then loaded and the FSM goes → FETCH:
    - BR with TAKEN=1: PC+4+(sext(imm)<<2).
    - JAL: ALUQ.
    - Otherwise: PC+4.
- Illegal op: `illegalOp`=1 in WB, `regWe`=0, PC←PC+4.
- Output validity:
  - ALU controls are decoded from IR and held stable through EXEC, MEM and WB. In INIT/FETCH/DECODE they are 0.
  - Field outputs always reflect IR.
- Arithmetic: all PC math is 32-bit modulo; PC wraps from `32'hFFFF_FFFC` to 0 without a flag.
- Inputs outside their owning state are ignored: `imemValid` outside FETCH, `dmemReady` outside MEM.

## Timing
- Reset (`reset_n`=0, asynchronous): state=INIT, PC=`RESET_PC`, IR=0, ALUQ=0, TAKEN=0.
  - All outputs are 0 except `imemAddr`=`RESET_PC` and `pcPlus4`=`RESET_PC`+4.
  - Reset asserted mid-operation aborts any request immediately; no `regWe` or `dmemReq` is left asserted.
- Cycle counts with zero-wait memories: ALU/CMP/BR/JAL = 4 cycles (FETCH, DECODE, EXEC, WB); LW = 5; SW = 4. Each memory wait cycle adds 1.
- `regWe` lasts exactly one cycle per writing instruction.
- `dmemReq` rises on MEM entry and falls the cycle after `dmemReady` is sampled high.
- Fetch is not issued before the PC update is registered: `imemAddr` changes on the same edge FETCH is entered.

## Test plan
- Reset release, `imemData`=ALUR add r3=r1+r2, `imemValid` held 1 → `imemReq` rises 1 cycle after release; in EXEC `aluAltOp`=0, `aluFunc`=0000, `aluSrcImm`=0; in WB `regWe`=1, `rdAddr`=3, `regWrSel`=0; next `imemAddr`=4.
- BR `fn`=0001, imm=3, PC=0x10, `beqIn`=1 → next `imemAddr`=0x20. Same with `beqIn`=0 → 0x14, `regWe` never asserted.
- LW imm=-4 with `dmemReady` delayed 3 cycles → `dmemAddr`=ALU result, `dmemWe`=0, `dmemReq` held 4 cycles, `regWe`=1 with `regWrSel`=1; total 8 cycles.
- JAL imm=2, rs1 value 0x100 (`aluResult`=0x108), PC=0x40 → `immOut`=8, `regWrSel`=2, `pcPlus4`=0x44 written; next PC=0x108.
- `imemData` with op=1111 → `illegalOp` pulses once in WB, no `regWe`, PC advances by 4.
- `reset_n` pulled low while in MEM with `dmemReq`=1 → `dmemReq`=0 immediately, state INIT, PC=`RESET_PC`; a late `dmemReady` is ignored.
